// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state encoding for the SPI frame master
package spi_pkg;
    localparam int FRAME_BITS = 14;
    localparam int TX_BITS    = 10;
    localparam int RX_BITS    = 4;
    localparam int OPND_W     = 4;
    localparam int OP_W       = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;
endpackage

// File: rtl/sclk_gen.sv
// rtl/sclk_gen.sv - CLK_DIV half-period counter giving the SPI clock level and edge strobes
module sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic slck,
    output logic tick,
    output logic rise,
    output logic fall
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Strobes flag the cycle whose closing edge flips the level.
    assign tick = en && (cnt == LAST);
    assign rise = tick && !slck;
    assign fall = tick && slck;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            slck <= 1'b0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                slck <= ~slck;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_master_frame.sv
// rtl/spi_master_frame.sv - mode-0 SPI master sending one operand frame and capturing a 4-bit result
module spi_master_frame
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OPND_W-1:0] num1,
    input  logic [OPND_W-1:0] num2,
    input  logic [OP_W-1:0]   operacion,
    output logic              busy,
    output logic              done,
    output logic [RX_BITS-1:0] resultado,
    output logic              CS,
    output logic              SLCK,
    output logic              MOSI,
    input  logic              MISO
);
    state_t state, state_next;

    logic [TX_BITS-1:0] tx_sh;
    logic [RX_BITS-1:0] rx_sh;
    logic [3:0]         bit_cnt;
    logic               gen_en, gen_clr, tick, rise, fall;
    logic               last_fall;

    sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (gen_en),
        .clr  (gen_clr),
        .slck (SLCK),
        .tick (tick),
        .rise (rise),
        .fall (fall)
    );

    assign last_fall = (state == SHIFT) && fall && (bit_cnt == 4'(FRAME_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   if (tick) state_next = SHIFT;
            SHIFT:   if (last_fall) state_next = HOLD;
            HOLD:    if (tick) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The clock generator runs through SETUP and HOLD only as a timer; clearing it
    // at their final tick keeps SLCK low outside SHIFT.
    always_comb begin
        gen_en  = (state == SETUP) || (state == SHIFT) || (state == HOLD);
        gen_clr = !gen_en || ((state != SHIFT) && tick);
        CS      = !gen_en;
        busy    = (state != IDLE);
        done    = (state == DONE);
        MOSI    = 1'b0;
        if ((state == SETUP) || ((state == SHIFT) && (bit_cnt < 4'(TX_BITS))))
            MOSI = tx_sh[TX_BITS-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sh     <= '0;
            rx_sh     <= '0;
            bit_cnt   <= '0;
            resultado <= '0;
        end else begin
            if (state == IDLE) begin
                bit_cnt <= '0;
                if (start) tx_sh <= {num1, num2, operacion};
            end
            if ((state == SHIFT) && fall) begin
                bit_cnt <= bit_cnt + 4'd1;
                tx_sh   <= {tx_sh[TX_BITS-2:0], 1'b0};
            end
            if ((state == SHIFT) && rise && (bit_cnt >= 4'(TX_BITS)))
                rx_sh <= {rx_sh[RX_BITS-2:0], MISO};
            if ((state == HOLD) && tick)
                resultado <= rx_sh;
        end
    end
endmodule

// File: tb/tb_spi_master_frame.sv
// tb/tb_spi_master_frame.sv - directed self-checking bench for spi_master_frame at CLK_DIV 4 and 1
module tb_spi_master_frame;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] num1 = 4'h0;
    logic [3:0] num2 = 4'h0;
    logic [1:0] operacion = 2'b00;
    logic       miso = 1'b0;

    logic       busy4, done4, cs4, slck4, mosi4;
    logic       busy1, done1, cs1, slck1, mosi1;
    logic [3:0] res4, res1;
    logic       start4, start1;
    logic       busy, done, cs, slck, mosi;
    logic [3:0] res;

    assign start4 = start && !sel;
    assign start1 = start && sel;
    assign busy = sel ? busy1 : busy4;
    assign done = sel ? done1 : done4;
    assign cs   = sel ? cs1   : cs4;
    assign slck = sel ? slck1 : slck4;
    assign mosi = sel ? mosi1 : mosi4;
    assign res  = sel ? res1  : res4;

    spi_master_frame #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .num1(num1), .num2(num2), .operacion(operacion),
        .busy(busy4), .done(done4), .resultado(res4), .CS(cs4), .SLCK(slck4), .MOSI(mosi4), .MISO(miso)
    );

    spi_master_frame #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .num1(num1), .num2(num2), .operacion(operacion),
        .busy(busy1), .done(done1), .resultado(res1), .CS(cs1), .SLCK(slck1), .MOSI(mosi1), .MISO(miso)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cyc0 = 0;
    int rise_cnt = 0, fall_cnt = 0, toggles = 0, slck_high = 0;
    int done_cnt = 0, done_cyc = 0, done_cyc_prev = 0;
    int cs_hi_run = 0, last_cs_gap = 0;
    logic prev_slck = 1'b0, prev_cs = 1'b1;
    logic [13:0] mosi_bits = '0;
    logic [3:0]  slave_res = 4'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clk cycle plus the slave model: MISO changes after each SLCK fall, result bits follow fall 10.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (prev_cs && !cs) begin
            rise_cnt = 0; fall_cnt = 0; toggles = 0; slck_high = 0; mosi_bits = '0;
            last_cs_gap = cs_hi_run;
        end
        if (!cs) begin
            if (slck && !prev_slck) begin
                mosi_bits = {mosi_bits[12:0], mosi};
                rise_cnt++;
            end
            if (!slck && prev_slck) fall_cnt++;
            if (slck != prev_slck) toggles++;
            if (slck) slck_high++;
        end
        miso = (!cs && fall_cnt >= 10 && fall_cnt <= 13) ? slave_res[13 - fall_cnt] : 1'b0;
        if (done) begin
            done_cnt++;
            done_cyc_prev = done_cyc;
            done_cyc = cyc;
        end
        cs_hi_run = cs ? cs_hi_run + 1 : 0;
        prev_slck = slck;
        prev_cs = cs;
    endtask

    task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, input logic [3:0] sres);
        num1 = a; num2 = b; operacion = op; slave_res = sres;
        start = 1'b1;
        cyc0 = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0;
        int k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < budget) begin
            step();
            start = 1'b0;
            k++;
        end
        check_eq({tag, "_timeout"}, done_cnt != n0, 1);
    endtask

    initial begin
        int busy_low;
        int cs_low;
        int dn;
        repeat (3) step();
        rst = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("idle_cs", cs, 1);
            check_eq("idle_slck", slck, 0);
            check_eq("idle_mosi", mosi, 0);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_done", done, 0);
            check_eq("idle_res", res, 0);
        end

        // 2: basic frame, CLK_DIV=4
        launch(4'h5, 4'h3, 2'b00, 4'b1000);
        step();
        start = 1'b0;
        check_eq("t2_busy_c1", busy, 1);
        check_eq("t2_cs_c1", cs, 0);
        check_eq("t2_mosi_c1", mosi, 0);
        dn = done_cnt;
        wait_done("t2", 200);
        check_eq("t2_done_cyc", done_cyc - cyc0, 121);
        check_eq("t2_res", res, 4'h8);
        check_eq("t2_mosi_bits", mosi_bits, 14'b0101_0011_00_0000);
        check_eq("t2_rises", rise_cnt, 14);
        step();
        check_eq("t2_done_pulse", done, 0);
        check_eq("t2_busy_end", busy, 0);
        check_eq("t2_done_count", done_cnt - dn, 1);

        // 3: start during frame and during DONE is ignored
        launch(4'hC, 4'h1, 2'b10, 4'h6);
        busy_low = 0;
        cs_low = 0;
        for (int k = 1; k <= 128; k++) begin
            step();
            if (k <= 121 && !busy) busy_low++;
            if (k >= 123 && !cs) cs_low++;
            if (k == 10 || k == 121) begin
                start = 1'b1; num1 = 4'hF; num2 = 4'hF; operacion = 2'b11;
            end else begin
                start = 1'b0;
            end
        end
        check_eq("t3_done_cyc", done_cyc - cyc0, 121);
        check_eq("t3_res", res, 4'h6);
        check_eq("t3_mosi_bits", mosi_bits, {4'hC, 4'h1, 2'b10, 4'h0});
        check_eq("t3_busy_low", busy_low, 0);
        check_eq("t3_no_restart", cs_low, 0);

        // 4: reset mid-frame
        launch(4'hA, 4'h5, 2'b11, 4'h9);
        dn = done_cnt;
        for (int k = 1; k <= 50; k++) begin
            step();
            start = 1'b0;
        end
        rst = 1'b1;
        step();
        check_eq("t4_cs", cs, 1);
        check_eq("t4_slck", slck, 0);
        check_eq("t4_busy", busy, 0);
        check_eq("t4_res", res, 0);
        check_eq("t4_mosi", mosi, 0);
        rst = 1'b0;
        repeat (130) step();
        check_eq("t4_no_done", done_cnt - dn, 0);
        launch(4'hA, 4'h5, 2'b11, 4'h9);
        wait_done("t4b", 200);
        check_eq("t4b_done_cyc", done_cyc - cyc0, 121);
        check_eq("t4b_res", res, 4'h9);
        check_eq("t4b_mosi_bits", mosi_bits, {4'hA, 4'h5, 2'b11, 4'h0});

        // 5: back-to-back with start held high
        repeat (3) step();
        num1 = 4'h1; num2 = 4'h2; operacion = 2'b01; slave_res = 4'hA;
        start = 1'b1;
        cyc0 = cyc;
        dn = done_cnt;
        for (int k = 0; k < 300 && done_cnt - dn < 1; k++) step();
        check_eq("t5_first_done", done_cnt - dn, 1);
        check_eq("t5_res_a", res, 4'hA);
        check_eq("t5_done_cyc", done_cyc - cyc0, 121);
        slave_res = 4'h3;
        for (int k = 0; k < 300 && done_cnt - dn < 2; k++) step();
        check_eq("t5_second_done", done_cnt - dn, 2);
        check_eq("t5_res_3", res, 4'h3);
        check_eq("t5_done_gap", done_cyc - done_cyc_prev, 122);
        check_eq("t5_cs_gap", last_cs_gap, 2);
        start = 1'b0;
        repeat (4) step();
        check_eq("t5_idle", busy, 0);

        // 6: CLK_DIV=1 instance
        sel = 1'b1;
        repeat (2) step();
        launch(4'h9, 4'h6, 2'b01, 4'hF);
        wait_done("t6", 100);
        check_eq("t6_done_cyc", done_cyc - cyc0, 31);
        check_eq("t6_res", res, 4'hF);
        check_eq("t6_mosi_bits", mosi_bits, 14'b1001_0110_01_0000);
        check_eq("t6_rises", rise_cnt, 14);
        check_eq("t6_toggles", toggles, 28);
        check_eq("t6_slck_high", slck_high, 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
